mult2x2_seq_ctrl: RTL and testbench

//   Sequencer that builds a WIDTH x WIDTH unsigned product from one external
//   2x2-bit digit multiplier.

---
 rtl/mult2x2_seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mult2x2_seq_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mult2x2_seq_ctrl.sv
// mult2x2_seq_ctrl
//   Builds a WIDTH x WIDTH unsigned product using one external combinational
//   2x2-bit digit multiplier. The operands are split into D = WIDTH/2 radix-4
//   digits. One digit pair is presented per cycle on mx/my. The 4-bit partial
//   product returned on mp is shifted and accumulated in the same cycle.
//
//   Ports
//     clk      rising-edge clock
//     rst      synchronous active-high reset
//     start    request, sampled only while IDLE
//     a, b     operands, latched when start is accepted
//     mx, my   digit pair driven to the 2x2 multiplier (0 outside BUSY)
//     mp       2x2 product, combinational from mx/my
//     busy     high while the digit loop runs (D*D cycles)
//     done     one-cycle pulse, product valid
//     product  result, held until the next completion or reset
//
//   Build option
//     EARLY_ZERO_EN : a zero operand finishes on the accepting edge
//                     (product 0, done next cycle, no BUSY cycles)
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start; done pulses here for one cycle after a run
//   BUSY  | stepping digit pairs (i = a digit, j = b digit), j fastest
module mult2x2_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [1:0]         mx,
    output logic [1:0]         my,
    input  logic [3:0]         mp,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int D  = WIDTH / 2;
    localparam int IW = (D > 1) ? $clog2(D) : 1;
    localparam logic [IW-1:0] LAST = IW'(D - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_lat_q, a_lat_d;
    logic [WIDTH-1:0]     b_lat_q, b_lat_d;
    logic [IW-1:0]        i_q, i_d;
    logic [IW-1:0]        j_q, j_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 done_q, done_d;

    logic [1:0]           mx_sel, my_sel;
    logic [2*WIDTH-1:0]   mp_ext;
    logic [2*WIDTH-1:0]   term;

    // Digit select with constant indices keeps every operand bit reachable.
    always_comb begin
        mx_sel = 2'b00;
        my_sel = 2'b00;
        for (int k = 0; k < D; k++) begin
            if (i_q == IW'(k)) mx_sel = a_lat_q[2*k +: 2];
            if (j_q == IW'(k)) my_sel = b_lat_q[2*k +: 2];
        end
    end

    // Partial product weight is 4^(i+j); the shift amount is evaluated at
    // 32 bits so i+j cannot wrap.
    always_comb begin
        mp_ext      = '0;
        mp_ext[3:0] = mp;
        term        = mp_ext << (2 * (i_q + j_q));
    end

    always_comb begin
        state_d   = state_q;
        a_lat_d   = a_lat_q;
        b_lat_d   = b_lat_q;
        i_d       = i_q;
        j_d       = j_q;
        acc_d     = acc_q;
        product_d = product_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_lat_d = a;
                    b_lat_d = b;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
`ifdef EARLY_ZERO_EN
                    if (a == '0 || b == '0) begin
                        product_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
`else
                    state_d = BUSY;
`endif
                end
            end
            BUSY: begin
                acc_d = acc_q + term;
                if (j_q == LAST) begin
                    j_d = '0;
                    if (i_q == LAST) begin
                        i_d       = '0;
                        product_d = acc_q + term;
                        done_d    = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        i_d = i_q + IW'(1);
                    end
                end else begin
                    j_d = j_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_lat_q   <= '0;
            b_lat_q   <= '0;
            i_q       <= '0;
            j_q       <= '0;
            acc_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_lat_q   <= a_lat_d;
            b_lat_q   <= b_lat_d;
            i_q       <= i_d;
            j_q       <= j_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q == BUSY);
    assign mx      = busy ? mx_sel : 2'b00;
    assign my      = busy ? my_sel : 2'b00;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_mult2x2_seq_ctrl.sv
// Bench for mult2x2_seq_ctrl (WIDTH=4). The 2x2 slice is modelled as mx*my.
// Inputs are driven and outputs sampled on the falling edge.
// Expected values come from plain arithmetic: product = a*b, D*D busy
// cycles, and digit pairs visited in order (a digit i, b digit j), j fastest.
module tb_mult2x2_seq_ctrl;

    localparam int WIDTH = 4;
    localparam int D     = WIDTH / 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [WIDTH-1:0]   a, b;
    logic [1:0]         mx, my;
    logic [3:0]         mp;
    logic               busy, done;
    logic [2*WIDTH-1:0] product;

    int checks = 0;
    int errors = 0;

    mult2x2_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .mx      (mx),
        .my      (my),
        .mp      (mp),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    assign mp = 4'(mx * my);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic bit zero_skip(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
`ifdef EARLY_ZERO_EN
        return (av == 0) || (bv == 0);
`else
        return 1'b0;
`endif
    endfunction

    // Called at a falling edge with the DUT idle. Presents start and the
    // operands, then follows the run until done. hold keeps start asserted;
    // inj >= 0 asserts start with a=7,b=7 in that busy cycle (must be ignored).
    task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input bit hold, input int inj);
        logic [3:0] seen[$];
        logic [3:0] exp_pair;
        int lat, bcnt, exp_lat;
        bit fin;
        start = 1'b1;
        a     = av;
        b     = bv;
        exp_lat = zero_skip(av, bv) ? 0 : D * D;
        lat  = 0;
        bcnt = 0;
        fin  = 1'b0;
        while (!fin) begin
            @(negedge clk);
            if (busy) begin
                bcnt++;
                seen.push_back({mx, my});
            end else begin
                check("idle_mx", {30'd0, mx}, 0);
                check("idle_my", {30'd0, my}, 0);
            end
            if (done) begin
                check("done_busy_overlap", {31'd0, busy}, 0);
                fin = 1'b1;
            end else begin
                lat++;
                if (lat > 40) begin
                    check("done_timeout", 1, 0);
                    fin = 1'b1;
                end
                if (!hold) start = (lat - 1 == inj);
                if (lat - 1 == inj) begin
                    a = 4'd7;
                    b = 4'd7;
                end else begin
                    a = 4'($urandom_range(0, 15));
                    b = 4'($urandom_range(0, 15));
                end
            end
        end
        check("latency", lat, exp_lat);
        check("busy_cycles", bcnt, exp_lat);
        check("product", {24'd0, product}, av * bv);
        if (!zero_skip(av, bv)) begin
            check("pair_count", seen.size(), D * D);
            for (int i = 0; i < D; i++)
                for (int j = 0; j < D; j++) begin
                    exp_pair = {av[2*i +: 2], bv[2*j +: 2]};
                    if (seen.size() > 0) check("digit_pair", {28'd0, seen.pop_front()}, {28'd0, exp_pair});
                end
        end
    endtask

    task automatic idle_check(input logic [2*WIDTH-1:0] exp_p);
        start = 1'b0;
        @(negedge clk);
        check("done_pulse_end", {31'd0, done}, 0);
        check("idle_busy", {31'd0, busy}, 0);
        check("product_hold", {24'd0, product}, {24'd0, exp_p});
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_product", {24'd0, product}, 0);
        check("rst_mx", {30'd0, mx}, 0);
        check("rst_my", {30'd0, my}, 0);
        rst = 1'b0;
        @(negedge clk);

        do_op(4'd3, 4'd2, 1'b0, -1);
        idle_check(8'd6);

        do_op(4'd15, 4'd15, 1'b0, -1);
        idle_check(8'd225);
        idle_check(8'd225);

        do_op(4'd0, 4'd9, 1'b0, -1);
        idle_check(8'd0);

        do_op(4'd5, 4'd6, 1'b0, 1);
        idle_check(8'd30);
        idle_check(8'd30);

        // Reset in the second busy cycle.
        start = 1'b1;
        a     = 4'd9;
        b     = 4'd9;
        @(negedge clk);
        start = 1'b0;
        check("pre_rst_busy", {31'd0, busy}, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", {31'd0, busy}, 0);
        check("mid_rst_done", {31'd0, done}, 0);
        check("mid_rst_product", {24'd0, product}, 0);
        check("mid_rst_mx", {30'd0, mx}, 0);
        check("mid_rst_my", {30'd0, my}, 0);
        do_op(4'd2, 4'd3, 1'b0, -1);
        idle_check(8'd6);

        // start held high: second request accepted in the done cycle.
        do_op(4'd4, 4'd4, 1'b1, -1);
        do_op(4'd1, 4'd13, 1'b1, -1);
        idle_check(8'd13);

        for (int n = 0; n < 30; n++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) ra = '0;
            do_op(ra, rb, 1'b0, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1);
            if ($urandom_range(0, 1) == 1) idle_check(8'(ra * rb));
        end
        start = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
